// File: rtl/wash_pkg.sv
// wash_pkg
// Shared phase codes of the washing-machine sequencing FSM, used by the
// FSM, the washer top level and the phase-duration timer.
package wash_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SOAK   = 3'd1;
    localparam logic [2:0] WASH1  = 3'd2;
    localparam logic [2:0] RINSE2 = 3'd3;
    localparam logic [2:0] WASH2  = 3'd4;
    localparam logic [2:0] RINSE1 = 3'd5;
    localparam logic [2:0] SPIN   = 3'd6;
    localparam logic [2:0] STOP   = 3'd7;

    // True for phases that run against a duration (soak through spin).
    function automatic logic is_timed(input logic [2:0] phase);
        return (phase != IDLE) && (phase != STOP);
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// wash_phase_timer
// Drives the sequencing FSM's timer input. Every phase entry reloads a
// down-counter with that phase's duration; a one-cycle timer pulse is emitted
// when the count expires, after which the counter re-arms for the same phase.
// The lid-open stop phase freezes the count so that spin resumes where it
// paused instead of restarting.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears all registers
//   state_i      FSM phase code (see wash_pkg)
//   enable_i     count enable (motor/water ready); low freezes the count
//   timer_o      one-cycle expiry pulse to the FSM
//   remaining_o  cycles left in the current phase
//   active_o     high while state_i is a timed phase (soak..spin)
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int SOAK_T  = 20,
    parameter int WASH_T  = 40,
    parameter int RINSE_T = 30,
    parameter int SPIN_T  = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       state_i,
    input  logic             enable_i,
    output logic             timer_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] SOAK_D  = CNT_W'(SOAK_T);
    localparam logic [CNT_W-1:0] WASH_D  = CNT_W'(WASH_T);
    localparam logic [CNT_W-1:0] RINSE_D = CNT_W'(RINSE_T);
    localparam logic [CNT_W-1:0] SPIN_D  = CNT_W'(SPIN_T);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             timer_q, timer_d;

    function automatic logic [CNT_W-1:0] duration(input logic [2:0] phase);
        case (phase)
            SOAK:          return SOAK_D;
            WASH1, WASH2:  return WASH_D;
            RINSE2, RINSE1: return RINSE_D;
            SPIN:          return SPIN_D;
            default:       return '0;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q  <= IDLE;
            cnt_q   <= '0;
            timer_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        timer_d = 1'b0;

        if (state_i != prev_q) begin
            // Phase change takes priority over expiry, independent of enable.
            prev_d = state_i;
            if (state_i == IDLE) begin
                cnt_d = '0;
            end else if (state_i == STOP) begin
                cnt_d = cnt_q;
            end else if ((prev_q == STOP) && (state_i == SPIN)) begin
                // Lid closed again: resume the paused spin count.
                cnt_d = cnt_q;
            end else begin
                cnt_d = duration(state_i);
            end
        end else if (is_timed(state_i) && enable_i) begin
            if (cnt_q == ONE) begin
                // Expire and re-arm so a phase held by the FSM pulses periodically.
                timer_d = 1'b1;
                cnt_d   = duration(state_i);
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    assign timer_o     = timer_q;
    assign remaining_o = cnt_q;
    assign active_o    = is_timed(state_i);

endmodule

// File: tb/tb_wash_phase_timer.sv
module tb_wash_phase_timer;

    localparam int CNT_W   = 8;
    localparam int SOAK_T  = 4;
    localparam int WASH_T  = 6;
    localparam int RINSE_T = 3;
    localparam int SPIN_T  = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       state_i;
    logic             enable_i;
    logic             timer_o;
    logic [CNT_W-1:0] remaining_o;
    logic             active_o;

    int checks = 0;
    int errors = 0;

    // Reference model: phase last seen, cycles left, pending pulse.
    logic [2:0]       m_phase;
    logic [CNT_W-1:0] m_left;
    logic             m_pulse;

    wash_phase_timer #(
        .CNT_W(CNT_W), .SOAK_T(SOAK_T), .WASH_T(WASH_T),
        .RINSE_T(RINSE_T), .SPIN_T(SPIN_T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .state_i(state_i),
        .enable_i(enable_i),
        .timer_o(timer_o),
        .remaining_o(remaining_o),
        .active_o(active_o)
    );

    always #5 clock = ~clock;

    function automatic int phase_len(input logic [2:0] p);
        if (p == 3'd1) return SOAK_T;
        if (p == 3'd2 || p == 3'd4) return WASH_T;
        if (p == 3'd3 || p == 3'd5) return RINSE_T;
        if (p == 3'd6) return SPIN_T;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 3'd0;
        m_left  = '0;
        m_pulse = 1'b0;
    endtask

    // Apply one clock edge of the phase rules to the model.
    task automatic model_edge(input logic [2:0] s, input logic e);
        int len;
        len = phase_len(s);
        m_pulse = 1'b0;
        if (s != m_phase) begin
            if (s == 3'd0)
                m_left = '0;
            else if (s == 3'd7 || (m_phase == 3'd7 && s == 3'd6))
                m_left = m_left;
            else
                m_left = CNT_W'(len);
            m_phase = s;
        end else if (len != 0 && e) begin
            if (m_left == 1) begin
                m_pulse = 1'b1;
                m_left  = CNT_W'(len);
            end else begin
                m_left = m_left - 1'b1;
            end
        end
    endtask

    // One cycle: drive inputs, take an edge, compare all outputs to the model.
    task automatic cyc(input string tag, input logic [2:0] s, input logic e);
        state_i  = s;
        enable_i = e;
        @(posedge clock);
        model_edge(s, e);
        #1;
        chk({tag, ".remaining"}, 32'(remaining_o), 32'(m_left));
        chk({tag, ".timer"}, 32'(timer_o), 32'(m_pulse));
        chk({tag, ".active"}, 32'(active_o), 32'(phase_len(s) != 0));
        $display("%s state=%0d en=%0d remaining=%0d timer=%0d", tag, s, e, remaining_o, timer_o);
    endtask

    initial begin
        logic [2:0] rs;
        logic       re;

        // Reset and idle
        reset = 1'b1; state_i = 3'd0; enable_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset.remaining", 32'(remaining_o), 32'd0);
        chk("reset.timer", 32'(timer_o), 32'd0);
        chk("reset.active", 32'(active_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle", 3'd0, 1'b1);

        // Soak expiry: 4,3,2,1 then pulse with reload to 4
        cyc("soak", 3'd1, 1'b1);
        chk("soak.load", 32'(remaining_o), 32'd4);
        cyc("soak", 3'd1, 1'b1);
        cyc("soak", 3'd1, 1'b1);
        cyc("soak", 3'd1, 1'b1);
        chk("soak.last", 32'(remaining_o), 32'd1);
        chk("soak.nopulse", 32'(timer_o), 32'd0);
        cyc("soak", 3'd1, 1'b1);
        chk("soak.pulse", 32'(timer_o), 32'd1);
        chk("soak.reload", 32'(remaining_o), 32'd4);
        cyc("soak", 3'd1, 1'b1);
        chk("soak.pulse_width", 32'(timer_o), 32'd0);

        // Periodic re-arm in rinse2: pulses after E0+3, E0+6, E0+9
        cyc("rinse", 3'd3, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            cyc("rinse", 3'd3, 1'b1);
            chk("rinse.periodic", 32'(timer_o), 32'((k % 3) == 0));
        end

        // Lid pause and resume
        cyc("spin", 3'd6, 1'b1);
        cyc("spin", 3'd6, 1'b1);
        cyc("spin", 3'd6, 1'b1);
        chk("spin.pre_stop", 32'(remaining_o), 32'd3);
        for (int i = 0; i < 20; i++) cyc("stop", 3'd7, 1'b1);
        chk("stop.held", 32'(remaining_o), 32'd3);
        cyc("resume", 3'd6, 1'b1);
        chk("resume.noreload", 32'(remaining_o), 32'd3);
        cyc("resume", 3'd6, 1'b1);
        cyc("resume", 3'd6, 1'b1);
        chk("resume.early", 32'(timer_o), 32'd0);
        cyc("resume", 3'd6, 1'b1);
        chk("resume.pulse", 32'(timer_o), 32'd1);

        // Enable freeze in wash1
        cyc("wash", 3'd2, 1'b1);
        cyc("wash", 3'd2, 1'b1);
        cyc("wash", 3'd2, 1'b1);
        chk("wash.pre_freeze", 32'(remaining_o), 32'd4);
        for (int i = 0; i < 7; i++) cyc("freeze", 3'd2, 1'b0);
        chk("freeze.held", 32'(remaining_o), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            cyc("thaw", 3'd2, 1'b1);
            chk("thaw.pulse", 32'(timer_o), 32'(i == 4));
        end

        // Reset mid-soak
        cyc("soak2", 3'd1, 1'b1);
        cyc("soak2", 3'd1, 1'b1);
        cyc("soak2", 3'd1, 1'b1);
        chk("soak2.pre_reset", 32'(remaining_o), 32'd2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midreset.remaining", 32'(remaining_o), 32'd0);
        chk("midreset.timer", 32'(timer_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cyc("postreset", 3'd1, 1'b1);
        chk("postreset.reload", 32'(remaining_o), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            cyc("postreset", 3'd1, 1'b1);
            chk("postreset.pulse", 32'(timer_o), 32'(i == 4));
        end

        // Randomized phase sequences against the model
        rs = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rs = 3'($urandom_range(0, 7));
            re = ($urandom_range(0, 3) != 0);
            cyc("rand", rs, re);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase-duration controller that drives the `timer` input of the washing-machine sequencing FSM. It watches the FSM's 3-bit `state` output and reloads a down-counter with a per-phase duration on every phase entry. It emits a one-cycle `timer` pulse when the duration expires, and freezes the count while the lid-open `stop` phase is active, so spin resumes where it paused. It sits beside the FSM in the washer top level, replacing the free-running or hard-tied `timer` stimulus.

## Interface
- `CNT_W`, 8: counter width.
- `SOAK_T`, 20: soak duration, enabled clock cycles; legal range 2..2^CNT_W-1.
- `WASH_T`, 40: duration of wash1 and wash2; same range.
- `RINSE_T`, 30: duration of rinse1 and rinse2; same range.
- `SPIN_T`, 25: spin duration; same range.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `state`  in  3  FSM phase code: 0 idle, 1 soak, 2 wash1, 3 rinse2, 4 wash2, 5 rinse1, 6 spin, 7 stop.
- `enable`  in  1  count enable (motor/water-ready); low freezes counting.
- `timer`  out  1  one-cycle expiry pulse to the FSM.
- `remaining`  out  CNT_W  current count value (cycles left in phase).
- `active`  out  1  high while `state` is a timed phase (1..6).

## Operation
- Registers: `prev_state` (3 bits), `cnt` (CNT_W bits), `timer`. `remaining` = `cnt`. `active` is combinational from `state`.
- Duration select: 1→SOAK_T; 2,4→WASH_T; 3,5→RINSE_T; 6→SPIN_T.
- Phase change (`state != prev_state`), evaluated every edge regardless of `enable`:
  - `prev_state <= state`, `timer <= 0`.
  - New state idle: `cnt <= 0`.
  - New state stop: `cnt` held.
  - Transition 7→6 (stop→spin): `cnt` held. This is a resume, not a reload.
  - Any other transition into 1..6: `cnt <= duration(state)`.
- No phase change, state timed (1..6), `enable`=1:
  - If `cnt==1`: `timer <= 1`, `cnt <= duration(state)` (periodic re-arm, so rinse1 with double_wash low pulses repeatedly).
  - Else: `cnt <= cnt-1`, `timer <= 0`.
- No phase change, `enable`=0, or state idle or stop: `cnt` held, `timer <= 0`.
- Phase change and `cnt==1` on the same edge: the phase change wins, and no pulse is issued.
- The minimum duration is 2. The FSM's `state` output lags its internal state by one cycle, so a shorter period could double-advance it.
- Reset mid-phase: all registers clear immediately. After release, a held non-idle `state` counts as a phase change on the first edge and is reloaded.

## Timing
- Reset values: `prev_state`=0, `cnt`=0, `timer`=0, `remaining`=0. `active` follows `state`.
- Load edge E0: the edge on which the phase change is detected. With `enable` held high, `timer` is high for exactly the cycle after edge E0+D and low otherwise. `remaining` reads D, D-1, …, 1, D, …
- Each low-`enable` cycle extends expiry by one cycle.
- Latency from `state` change to reload: one edge.

## Structure
- Shared package `wash_pkg`: phase-code localparams (IDLE..STOP, 3'd0..3'd7), shared with the FSM and top level.
- No sub-module. Duration select is a local function inside the block.
- Expected size: roughly 150 lines of RTL.

## Test plan
Bench parameters: CNT_W=8, SOAK_T=4, WASH_T=6, RINSE_T=3, SPIN_T=5.
- **Reset and idle:** assert `reset`, then hold `state`=0 for 10 cycles after release → `timer`=0, `remaining`=0, `active`=0 throughout.
- **Soak expiry:** `state` 0→1, `enable`=1 → `remaining` reads 4,3,2,1; `timer` pulses one cycle after E0+4; `remaining` reloads to 4.
- **Periodic re-arm:** hold `state`=3 for 10 cycles → pulses after E0+3, E0+6 and E0+9, each exactly one cycle.
- **Lid pause and resume:** spin with `remaining`=3, `state`→7 for 20 cycles → `remaining` stays 3 and `timer`=0. Then `state`→6 → no reload; pulse after 3 cycles.
- **Enable freeze:** wash1 with `remaining`=4, `enable`=0 for 7 cycles → `remaining` frozen at 4. Then `enable`=1 → pulse 4 cycles later.
- **Reset mid-soak:** assert `reset` with `remaining`=2 → `timer`=0 and `remaining`=0 immediately. Release with `state`=1 held → first edge reloads 4; pulse follows 4 cycles later.
